// File: rtl/tank_pos_tx.sv
// -----------------------------------------------------------------------------
// tank_pos_tx
//
// Transmit side of the tank-position link. On each rising edge of vsync,
// while enabled and idle, the local tank position is latched. It is then sent
// to the remote board as a 5-byte 8N1 UART packet, LSB first:
//   B0 = SYNC_BYTE
//   B1 = X[7:0]
//   B2 = Y[7:0]
//   B3 = {4'b0, X[9:8], Y[9:8]}
//   B4 = B1 ^ B2 ^ B3
// Bytes are sent back to back. Each one is a start bit, 8 data bits and a
// stop bit, and every bit lasts CLKS_PER_BIT clocks. A packet therefore keeps
// busy high for exactly 50*CLKS_PER_BIT cycles.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (legal >= 2)
//   SYNC_BYTE     packet header byte
//
// Ports
//   clk        in   pixel clock; the only clock
//   rst        in   asynchronous, active-low reset
//   enable     in   1 = send a packet on each frame trigger
//   vsync      in   frame trigger; a rising edge requests a packet
//   xpos       in   [9:0] local tank X
//   ypos       in   [9:0] local tank Y
//   tx         out  UART serial line, idle high (registered)
//   busy       out  high while a packet is being shifted out (registered)
//   sent       out  1-cycle pulse when the last stop bit completes (registered)
//   drop_cnt   out  [7:0] saturating count of triggers ignored while busy
//   dbg_state  out  [1:0] FSM state: 0 IDLE, 1 START, 2 DATA, 3 STOP
//
// Trigger semantics: a trigger (rising vsync) acts as a one-cycle request.
// The FSM accepts it only when it is in IDLE and enable is high. It
// then acts as "ready" and consumes the request on that edge. An enabled
// trigger that arrives while a packet is in flight cannot be held, so it is
// dropped and counted. A trigger that arrives while enable is low is ignored
// and is not counted.
// -----------------------------------------------------------------------------
module tank_pos_tx #(
  parameter int          CLKS_PER_BIT = 564,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       vsync,
  input  logic [9:0] xpos,
  input  logic [9:0] ypos,
  output logic       tx,
  output logic       busy,
  output logic       sent,
  output logic [7:0] drop_cnt,
  output logic [1:0] dbg_state
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e        state_q;
  logic          vsync_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [2:0]    byte_idx_q;
  logic [9:0]    x_q;
  logic [9:0]    y_q;
  logic          tx_q;
  logic          busy_q;
  logic          sent_q;
  logic [7:0]    drop_q;
  logic [7:0]    drop_d;

  logic          trig;
  logic          baud_end;
  logic [7:0]    b1;
  logic [7:0]    b2;
  logic [7:0]    b3;
  logic [7:0]    cur_byte;

  assign trig     = vsync & ~vsync_q;
  assign baud_end = (baud_q == BAUD_LAST);

  // The packet bytes come from the latched position. They are not taken from
  // the live inputs, so moving the tank mid-packet cannot corrupt it.
  assign b1 = x_q[7:0];
  assign b2 = y_q[7:0];
  assign b3 = {4'b0000, x_q[9:8], y_q[9:8]};

  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_idx_q)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = b1;
      3'd2:    cur_byte = b2;
      3'd3:    cur_byte = b3;
      default: cur_byte = b1 ^ b2 ^ b3;
    endcase
  end

  // Edge detector. Its reset value is 1, so a vsync that is already high
  // when reset is released does not count as a trigger.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vsync_q <= 1'b1;
    else      vsync_q <= vsync;
  end

  // Drop counter: counts enabled triggers that arrive while a packet is in
  // flight, and saturates at 255.
  always_comb begin
    drop_d = drop_q;
    if (trig && enable && (state_q != S_IDLE) && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_q <= 8'd0;
    else      drop_q <= drop_d;
  end

  // Packet FSM. tx, busy and sent are driven from registers here. Each value
  // is computed one edge ahead of the bit it belongs to, so the line changes
  // exactly at the bit boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      x_q        <= 10'd0;
      y_q        <= 10'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      sent_q     <= 1'b0;
    end else begin
      sent_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q       <= 1'b1;
          busy_q     <= 1'b0;
          baud_q     <= '0;
          bit_idx_q  <= 3'd0;
          byte_idx_q <= 3'd0;
          if (trig && enable) begin
            x_q     <= xpos;
            y_q     <= ypos;
            state_q <= S_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        S_START: begin
          if (baud_end) begin
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            state_q   <= S_DATA;
            tx_q      <= cur_byte[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= cur_byte[bit_idx_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        S_STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (byte_idx_q == 3'd4) begin
              // End of the last stop bit: busy drops in the same cycle that
              // sent pulses, and the FSM can accept a trigger right away.
              byte_idx_q <= 3'd0;
              state_q    <= S_IDLE;
              tx_q       <= 1'b1;
              busy_q     <= 1'b0;
              sent_q     <= 1'b1;
            end else begin
              // No idle gap between bytes: the next start bit begins at once.
              byte_idx_q <= byte_idx_q + 3'd1;
              state_q    <= S_START;
              tx_q       <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign sent      = sent_q;
  assign drop_cnt  = drop_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tank_pos_tx.sv
module tb_tank_pos_tx;

  localparam int CPB = 4;

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       vsync;
  logic [9:0] xpos;
  logic [9:0] ypos;
  logic       tx;
  logic       busy;
  logic       sent;
  logic [7:0] drop_cnt;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  tank_pos_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .vsync     (vsync),
    .xpos      (xpos),
    .ypos      (ypos),
    .tx        (tx),
    .busy      (busy),
    .sent      (sent),
    .drop_cnt  (drop_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Advance to the sample point, 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Make a rising vsync edge. On return the DUT has accepted the trigger, if
  // it was going to, and the first start-bit cycle is visible.
  task automatic trigger();
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step();
  endtask

  task automatic push_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
    exp_q.push_back(b4);
  endtask

  // Check a whole packet cycle by cycle, starting at its first start-bit
  // cycle. The line level and busy are checked on every cycle, and each byte
  // is decoded from the bit centres. On return the bench is at the cycle
  // where sent is expected.
  task automatic recv_packet(input string tag);
    logic [7:0] eb;
    logic [7:0] got;
    logic       lvl;
    for (int b = 0; b < 5; b++) begin
      eb  = exp_q.pop_front();
      got = 8'h00;
      for (int p = 0; p < 10; p++) begin
        for (int k = 0; k < CPB; k++) begin
          if (p == 0)      lvl = 1'b0;
          else if (p == 9) lvl = 1'b1;
          else             lvl = eb[p-1];
          check($sformatf("%s b%0d bit%0d cyc%0d line", tag, b, p, k),
                {29'd0, tx, busy, sent}, {29'd0, lvl, 1'b1, 1'b0});
          if (p >= 1 && p <= 8 && k == 1) got[p-1] = tx;
          step();
        end
      end
      check($sformatf("%s byte%0d", tag, b), {24'd0, got}, {24'd0, eb});
    end
    check($sformatf("%s sent pulse", tag), {29'd0, tx, busy, sent}, 32'b101);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int waited;
    rst    = 1'b0;
    enable = 1'b1;
    vsync  = 1'b0;
    xpos   = 10'd0;
    ypos   = 10'd0;

    // 1. Reset held while vsync toggles.
    for (int i = 0; i < 12; i++) begin
      step();
      vsync = ~vsync;
      check("t1 reset outputs", {20'd0, tx, busy, sent, drop_cnt, dbg_state},
            {20'd0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0});
    end
    vsync = 1'b1;
    rst   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t1 no packet after release", {30'd0, tx, busy}, 32'b10);
    end

    // 2. First packet.
    xpos = 10'h2A5;
    ypos = 10'h13C;
    push_pkt(8'hA5, 8'hA5, 8'h3C, 8'h09, 8'h90);
    trigger();
    recv_packet("t2");
    step();
    check("t2 after sent", {29'd0, tx, busy, sent}, 32'b100);
    step();
    check("t2 idle", {29'd0, tx, busy, sent}, 32'b100);

    // 3. Zero X, full-scale Y.
    xpos = 10'h000;
    ypos = 10'h3FF;
    push_pkt(8'hA5, 8'h00, 8'hFF, 8'h03, 8'hFC);
    trigger();
    recv_packet("t3");
    step();

    // 4a. A second edge mid-packet is dropped, and changing the inputs after
    //     acceptance does not change the packet.
    xpos = 10'h3C3;
    ypos = 10'h0F0;
    push_pkt(8'hA5, 8'hC3, 8'hF0, 8'h0C, 8'h3F);
    trigger();
    fork
      recv_packet("t4");
      begin
        repeat (20) step();
        vsync = 1'b0;
        xpos  = 10'h000;
        ypos  = 10'h000;
        step();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
      end
    join
    step();
    check("t4 drop one", {24'd0, drop_cnt}, 32'd1);

    // 5. A trigger while disabled does nothing.
    enable = 1'b0;
    trigger();
    check("t5 disabled no start", {30'd0, tx, busy}, 32'b10);
    repeat (8) step();
    check("t5 disabled still idle", {30'd0, tx, busy}, 32'b10);
    check("t5 drop unchanged", {24'd0, drop_cnt}, 32'd1);

    // 5b. Back-to-back packets: a trigger in the sent cycle is accepted.
    enable = 1'b1;
    xpos   = 10'h0AB;
    ypos   = 10'h254;
    push_pkt(8'hA5, 8'hAB, 8'h54, 8'h02, 8'hFD);
    trigger();
    vsync = 1'b0;
    recv_packet("t5a");
    vsync = 1'b1;
    xpos  = 10'h1E1;
    ypos  = 10'h00F;
    push_pkt(8'hA5, 8'hE1, 8'h0F, 8'h04, 8'hEA);
    step();
    recv_packet("t5b");
    step();

    // 4b. A long burst of edges saturates the drop counter.
    for (int i = 0; i < 700; i++) begin
      vsync = ~vsync;
      step();
    end
    vsync  = 1'b0;
    waited = 0;
    while (busy && waited < 400) begin
      step();
      waited++;
    end
    check("t4 drain busy", {31'd0, busy}, 32'd0);
    check("t4 drop saturated", {24'd0, drop_cnt}, 32'd255);

    // 6. Reset during DATA of B2 aborts at once, and the next packet is clean.
    xpos = 10'h155;
    ypos = 10'h2AA;
    trigger();
    repeat (96) step();
    check("t6 in data of b2", {30'd0, dbg_state}, 32'd2);
    #3 rst = 1'b0;
    #1;
    check("t6 async abort", {20'd0, tx, busy, sent, drop_cnt, dbg_state},
          {20'd0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0});
    step();
    step();
    rst = 1'b1;
    step();
    check("t6 idle after release", {30'd0, tx, busy}, 32'b10);
    push_pkt(8'hA5, 8'h55, 8'hAA, 8'h06, 8'hF9);
    trigger();
    recv_packet("t6");
    step();
    check("t6 final idle", {29'd0, tx, busy, sent}, 32'b100);

    // ---------------------------------------------------------------- report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
